// File: rtl/mini_cpu_pkg.sv
// mini_cpu_pkg
//   Shared definitions for the mini_cpu accumulator processor: instruction
//   and data widths, plus the 4-bit opcode map.
//   Opcodes 0xC..0xF are not listed; they all decode as NOP.
package mini_cpu_pkg;

  localparam int INSTR_W = 12;
  localparam int DATA_W  = 8;

  localparam logic [3:0] OP_CLR = 4'h0;
  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4;
  localparam logic [3:0] OP_OR  = 4'h5;
  localparam logic [3:0] OP_XOR = 4'h6;
  localparam logic [3:0] OP_NOT = 4'h7;
  localparam logic [3:0] OP_SHL = 4'h8;
  localparam logic [3:0] OP_SHR = 4'h9;
  localparam logic [3:0] OP_INC = 4'hA;
  localparam logic [3:0] OP_DEC = 4'hB;

endpackage

// File: rtl/mini_cpu_if.sv
// mini_cpu_if
//   Instruction/result bundle of the mini_cpu.
//     IN       : 12-bit instruction word (opcode in [11:8], immediate in [7:0])
//     RESULT   : 8-bit accumulator value
//     OVERFLOW : registered overflow flag
//   master : the sequencer driving instructions and observing results
//   slave  : the processor core
interface mini_cpu_if;
  import mini_cpu_pkg::*;

  logic [INSTR_W-1:0] IN;
  logic [DATA_W-1:0]  RESULT;
  logic               OVERFLOW;

  modport master (output IN, input RESULT, input OVERFLOW);
  modport slave  (input IN, output RESULT, output OVERFLOW);

endinterface

// File: rtl/mini_cpu_alu.sv
// mini_cpu_alu
//   Purely combinational datapath of the mini_cpu.
//   Ports:
//     op    [3:0] : opcode
//     a     [7:0] : current accumulator
//     b     [7:0] : immediate operand
//     y     [7:0] : next accumulator value
//     ovf         : next overflow flag value
//     wr_en       : low for NOP opcodes (accumulator and flag hold)
module mini_cpu_alu
  import mini_cpu_pkg::*;
(
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y,
  output logic              ovf,
  output logic              wr_en
);

  logic [DATA_W-1:0]   sum;
  logic [DATA_W-1:0]   diff;
  logic [2*DATA_W-1:0] shl_wide;

  assign sum  = a + b;
  assign diff = a - b;
  // Shifting into a double-width word keeps the bits that fall off the top,
  // so "any 1 shifted out" is just an OR of the upper half.
  assign shl_wide = {{DATA_W{1'b0}}, a} << b[2:0];

  always_comb begin
    y     = a;
    ovf   = 1'b0;
    wr_en = 1'b1;
    case (op)
      OP_CLR: y = '0;
      OP_LDI: y = b;
      OP_ADD: begin
        y   = sum;
        ovf = (a[7] == b[7]) && (sum[7] != a[7]);
      end
      OP_SUB: begin
        y   = diff;
        ovf = (a[7] != b[7]) && (diff[7] != a[7]);
      end
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      OP_XOR: y = a ^ b;
      OP_NOT: y = ~a;
      OP_SHL: begin
        y   = shl_wide[DATA_W-1:0];
        ovf = |shl_wide[2*DATA_W-1:DATA_W];
      end
      OP_SHR: y = a >> b[2:0];
      OP_INC: begin
        y   = a + 8'd1;
        ovf = (a == 8'h7F);
      end
      OP_DEC: begin
        y   = a - 8'd1;
        ovf = (a == 8'h80);
      end
      default: wr_en = 1'b0;
    endcase
  end

endmodule

// File: rtl/mini_cpu.sv
// mini_cpu
//   Single-cycle 8-bit accumulator processor. One instruction executes on
//   every rising CLK edge; results appear one cycle later.
//   Ports:
//     CLK   : clock, rising-edge active
//     RST_N : asynchronous active-low reset (clears ACC and OVERFLOW at once)
//     bus   : mini_cpu_if slave modport (IN instruction, RESULT, OVERFLOW)
module mini_cpu
  import mini_cpu_pkg::*;
(
  input  logic      CLK,
  input  logic      RST_N,
  mini_cpu_if.slave bus
);

  logic [3:0]        op;
  logic [DATA_W-1:0] imm;
  logic [DATA_W-1:0] alu_y;
  logic              alu_ovf;
  logic              alu_wr_en;

  logic [DATA_W-1:0] acc_d, acc_q;
  logic              ovf_d, ovf_q;

  assign op  = bus.IN[INSTR_W-1:DATA_W];
  assign imm = bus.IN[DATA_W-1:0];

  mini_cpu_alu u_alu (
    .op    (op),
    .a     (acc_q),
    .b     (imm),
    .y     (alu_y),
    .ovf   (alu_ovf),
    .wr_en (alu_wr_en)
  );

  always_comb begin
    acc_d = acc_q;
    ovf_d = ovf_q;
    if (alu_wr_en) begin
      acc_d = alu_y;
      ovf_d = alu_ovf;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end

  assign bus.RESULT   = acc_q;
  assign bus.OVERFLOW = ovf_q;

endmodule

// File: tb/tb_mini_cpu.sv
// tb_mini_cpu
//   Self-checking bench for mini_cpu: directed scenarios with known answers
//   followed by random instruction streams checked against an integer model.
module tb_mini_cpu;

  logic CLK;
  logic RST_N;

  mini_cpu_if bus ();

  mini_cpu dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference state, kept as plain integers 0..255 and 0/1.
  int m_acc = 0;
  int m_ovf = 0;

  function automatic int to_signed8(input int v);
    return (v > 127) ? v - 256 : v;
  endfunction

  // Behavioural model of one instruction, from the opcode rules.
  task automatic model_exec(input logic [11:0] instr);
    int op, b, a, sa, sb, s, sh, f;
    op = int'(instr[11:8]);
    b  = int'(instr[7:0]);
    a  = m_acc;
    sa = to_signed8(a);
    sb = to_signed8(b);
    case (op)
      0:  begin m_acc = 0; m_ovf = 0; end
      1:  begin m_acc = b; m_ovf = 0; end
      2:  begin s = sa + sb; m_acc = (a + b) % 256; m_ovf = (s > 127 || s < -128) ? 1 : 0; end
      3:  begin s = sa - sb; m_acc = (a - b + 256) % 256; m_ovf = (s > 127 || s < -128) ? 1 : 0; end
      4:  begin m_acc = a & b; m_ovf = 0; end
      5:  begin m_acc = a | b; m_ovf = 0; end
      6:  begin m_acc = a ^ b; m_ovf = 0; end
      7:  begin m_acc = 255 - a; m_ovf = 0; end
      8:  begin sh = b % 8; f = a * (1 << sh); m_acc = f % 256; m_ovf = (f > 255) ? 1 : 0; end
      9:  begin sh = b % 8; m_acc = a / (1 << sh); m_ovf = 0; end
      10: begin m_acc = (a + 1) % 256; m_ovf = (sa + 1 > 127) ? 1 : 0; end
      11: begin m_acc = (a + 255) % 256; m_ovf = (sa - 1 < -128) ? 1 : 0; end
      default: ;
    endcase
  endtask

  // Present an instruction, let one rising edge execute it, and settle
  // 1 time unit past the edge so outputs can be sampled.
  task automatic step(input logic [11:0] instr);
    bus.IN = instr;
    @(posedge CLK);
    #1;
    model_exec(instr);
  endtask

  task automatic test_reset;
    RST_N  = 1'b0;
    bus.IN = 12'h000;
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if (bus.RESULT !== 8'h00 || bus.OVERFLOW !== 1'b0) begin
      errors++;
      $display("FAIL reset_initial: RESULT=%h OVERFLOW=%b, expected 00/0", bus.RESULT, bus.OVERFLOW);
    end
    @(negedge CLK);
    RST_N = 1'b1;
    m_acc = 0; m_ovf = 0;

    step(12'h155);
    checks++;
    if (bus.RESULT !== 8'h55) begin
      errors++;
      $display("FAIL reset_ldi55: RESULT=%h expected 55", bus.RESULT);
    end
    step(12'h22B); // 0x55 + 0x2B = 0x80, signed overflow
    checks++;
    if (bus.RESULT !== 8'h80 || bus.OVERFLOW !== 1'b1) begin
      errors++;
      $display("FAIL reset_preload: RESULT=%h OVERFLOW=%b, expected 80/1", bus.RESULT, bus.OVERFLOW);
    end

    // Mid-cycle assertion must clear both outputs before the next edge.
    #2;
    RST_N = 1'b0;
    m_acc = 0; m_ovf = 0;
    #1;
    checks++;
    if (bus.RESULT !== 8'h00 || bus.OVERFLOW !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: RESULT=%h OVERFLOW=%b, expected 00/0", bus.RESULT, bus.OVERFLOW);
    end

    // Instructions are ignored while reset is held.
    bus.IN = 12'h1AA;
    @(posedge CLK);
    #1;
    checks++;
    if (bus.RESULT !== 8'h00 || bus.OVERFLOW !== 1'b0) begin
      errors++;
      $display("FAIL reset_ignore_in: RESULT=%h OVERFLOW=%b, expected 00/0", bus.RESULT, bus.OVERFLOW);
    end
    @(negedge CLK);
    RST_N = 1'b1;

    step(12'h000);
    checks++;
    if (bus.RESULT !== 8'h00 || bus.OVERFLOW !== 1'b0) begin
      errors++;
      $display("FAIL reset_clr: RESULT=%h OVERFLOW=%b, expected 00/0", bus.RESULT, bus.OVERFLOW);
    end
  endtask

  task automatic test_load;
    logic [11:0] instr [3]   = '{12'h1FF, 12'h101, 12'h180};
    logic [7:0]  expected [3] = '{8'hFF, 8'h01, 8'h80};
    for (int i = 0; i < 3; i++) begin
      step(instr[i]);
      checks++;
      if (bus.RESULT !== expected[i] || bus.OVERFLOW !== 1'b0) begin
        errors++;
        $display("FAIL load_%0d: RESULT=%h OVERFLOW=%b, expected %h/0", i, bus.RESULT, bus.OVERFLOW, expected[i]);
      end
    end
  endtask

  task automatic test_add;
    step(12'h17F);
    step(12'h201);
    checks++;
    if (bus.RESULT !== 8'h80 || bus.OVERFLOW !== 1'b1) begin
      errors++;
      $display("FAIL add_ovf: RESULT=%h OVERFLOW=%b, expected 80/1", bus.RESULT, bus.OVERFLOW);
    end
    // NOP after an overflowing ADD keeps both outputs.
    step(12'hC37);
    checks++;
    if (bus.RESULT !== 8'h80 || bus.OVERFLOW !== 1'b1) begin
      errors++;
      $display("FAIL nop_hold: RESULT=%h OVERFLOW=%b, expected 80/1", bus.RESULT, bus.OVERFLOW);
    end
    step(12'h200);
    checks++;
    if (bus.RESULT !== 8'h80 || bus.OVERFLOW !== 1'b0) begin
      errors++;
      $display("FAIL add_zero: RESULT=%h OVERFLOW=%b, expected 80/0", bus.RESULT, bus.OVERFLOW);
    end
    step(12'h1FF);
    step(12'h201);
    checks++;
    if (bus.RESULT !== 8'h00 || bus.OVERFLOW !== 1'b0) begin
      errors++;
      $display("FAIL add_carry: RESULT=%h OVERFLOW=%b, expected 00/0", bus.RESULT, bus.OVERFLOW);
    end
  endtask

  task automatic test_sub;
    step(12'h180);
    step(12'h301);
    checks++;
    if (bus.RESULT !== 8'h7F || bus.OVERFLOW !== 1'b1) begin
      errors++;
      $display("FAIL sub_ovf: RESULT=%h OVERFLOW=%b, expected 7F/1", bus.RESULT, bus.OVERFLOW);
    end
    step(12'h105);
    step(12'h307);
    checks++;
    if (bus.RESULT !== 8'hFE || bus.OVERFLOW !== 1'b0) begin
      errors++;
      $display("FAIL sub_borrow: RESULT=%h OVERFLOW=%b, expected FE/0", bus.RESULT, bus.OVERFLOW);
    end
  endtask

  task automatic test_logic_shift;
    logic [11:0] instr [5]    = '{12'h1F0, 12'h6FF, 12'h700, 12'h801, 12'h904};
    logic [7:0]  expected [5] = '{8'hF0, 8'h0F, 8'hF0, 8'hE0, 8'h0E};
    logic        exp_ovf  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      step(instr[i]);
      checks++;
      if (bus.RESULT !== expected[i] || bus.OVERFLOW !== exp_ovf[i]) begin
        errors++;
        $display("FAIL logic_shift_%0d: RESULT=%h OVERFLOW=%b, expected %h/%b",
                 i, bus.RESULT, bus.OVERFLOW, expected[i], exp_ovf[i]);
      end
    end
    // Shift by 0 (IMM[2:0]=0, upper bits ignored) leaves ACC and clears the flag.
    step(12'h1C0);
    step(12'h808);
    checks++;
    if (bus.RESULT !== 8'hC0 || bus.OVERFLOW !== 1'b0) begin
      errors++;
      $display("FAIL shl_zero: RESULT=%h OVERFLOW=%b, expected C0/0", bus.RESULT, bus.OVERFLOW);
    end
  endtask

  task automatic test_inc_hold;
    logic [7:0] expected [3] = '{8'h7F, 8'h80, 8'h81};
    logic       exp_ovf  [3] = '{1'b0, 1'b1, 1'b0};
    step(12'h17E);
    for (int i = 0; i < 3; i++) begin
      step(12'hA00);
      checks++;
      if (bus.RESULT !== expected[i] || bus.OVERFLOW !== exp_ovf[i]) begin
        errors++;
        $display("FAIL inc_hold_%0d: RESULT=%h OVERFLOW=%b, expected %h/%b",
                 i, bus.RESULT, bus.OVERFLOW, expected[i], exp_ovf[i]);
      end
    end
    step(12'h180);
    step(12'hB00);
    checks++;
    if (bus.RESULT !== 8'h7F || bus.OVERFLOW !== 1'b1) begin
      errors++;
      $display("FAIL dec_ovf: RESULT=%h OVERFLOW=%b, expected 7F/1", bus.RESULT, bus.OVERFLOW);
    end
  endtask

  task automatic test_random;
    logic [11:0] instr;
    logic [7:0]  exp_r;
    logic        exp_o;
    for (int i = 0; i < 400; i++) begin
      instr = 12'($urandom_range(0, 4095));
      // Every few steps steer ACC near the signed boundaries.
      if (i % 7 == 0)
        instr = {4'h1, 8'($urandom_range(0, 3) * 64 + $urandom_range(0, 1) * 63)};
      step(instr);
      exp_r = 8'(m_acc);
      exp_o = (m_ovf != 0);
      checks++;
      if (bus.RESULT !== exp_r || bus.OVERFLOW !== exp_o) begin
        errors++;
        $display("FAIL random_%0d instr=%h: RESULT=%h OVERFLOW=%b, expected %h/%b",
                 i, instr, bus.RESULT, bus.OVERFLOW, exp_r, exp_o);
      end
    end
  endtask

  initial begin
    RST_N  = 1'b0;
    bus.IN = 12'h000;
    test_reset();
    test_load();
    test_add();
    test_sub();
    test_logic_shift();
    test_inc_hold();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mini_cpu.md
# mini_cpu

Single-cycle 8-bit accumulator processor. It executes one 12-bit instruction word, presented on `IN`, on every rising clock edge. The accumulator is exposed on `RESULT` and a registered signed-overflow flag on `OVERFLOW`. It is a self-contained leaf block with no memory interface: an external sequencer or bench drives the instruction stream directly.

## Interface
Parameters: none. Widths are fixed: 12-bit instruction, 8-bit data.

Ports:
- `CLK` input 1: clock; all state changes on the rising edge.
- `RST_N` input 1: reset, asynchronous and active-low.
- `IN` input 12: instruction word. `IN[11:8]` is the opcode; `IN[7:0]` is the immediate operand `IMM`.
- `OVERFLOW` output 1: registered flag, updated by arithmetic ops.
- `RESULT` output 8: accumulator `ACC`, driven directly from its register.

## Operation
Opcode map (`ACC` is the value before the edge; `IMM = IN[7:0]`):
- 0x0 CLR: `ACC` <= 0; `OVERFLOW` <= 0.
- 0x1 LDI: `ACC` <= `IMM`; `OVERFLOW` <= 0.
- 0x2 ADD: `ACC` <= (`ACC` + `IMM`) mod 256; `OVERFLOW` <= two's-complement signed overflow. The flag is 1 when both operands have the same sign bit and the sum's sign bit differs.
- 0x3 SUB: `ACC` <= (`ACC` − `IMM`) mod 256; `OVERFLOW` <= signed overflow. The flag is 1 when the operand sign bits differ and the result sign bit differs from `ACC[7]`.
- 0x4 AND, 0x5 OR, 0x6 XOR: bitwise op of `ACC` with `IMM`; `OVERFLOW` <= 0.
- 0x7 NOT: `ACC` <= ~`ACC`; `IMM` ignored; `OVERFLOW` <= 0.
- 0x8 SHL: `ACC` <= `ACC` << `IMM[2:0]`, zero fill; `OVERFLOW` <= 1 if any 1 bit is shifted out.
- 0x9 SHR: `ACC` <= `ACC` >> `IMM[2:0]`, logical, zero fill; `OVERFLOW` <= 0.
- 0xA INC: `ACC` <= `ACC` + 1; `OVERFLOW` <= 1 only for the transition 0x7F -> 0x80.
- 0xB DEC: `ACC` <= `ACC` − 1; `OVERFLOW` <= 1 only for the transition 0x80 -> 0x7F.
- 0xC–0xF NOP: `ACC` and `OVERFLOW` hold.

General rules:
- `OVERFLOW` is not sticky. Every non-NOP instruction rewrites it.
- Arithmetic wraps modulo 256. No saturation.
- Shift amounts of 0 leave `ACC` unchanged and set `OVERFLOW` <= 0.

## Timing
- Reset: asserting `RST_N` low clears `ACC` to 0x00 and `OVERFLOW` to 0 immediately, without waiting for a clock edge.
- While `RST_N` is low, `IN` is ignored.
- Release of `RST_N` is synchronised by the integrator. The first instruction executes on the first rising edge with `RST_N` high.
- Latency is 1 cycle. The instruction sampled at edge N is reflected on `RESULT`/`OVERFLOW` right after edge N and holds until edge N+1.
- Throughput is one instruction per cycle. There is no handshake and no stall. A value held constant on `IN` re-executes on every edge; for example, ADD 0x01 held for 3 edges adds 3.
- Reset mid-stream aborts immediately. The instruction present at release is executed normally.
- `IN` must be stable around the rising edge. Outputs are glitch-free register outputs.

## Structure
- A shared package `mini_cpu_pkg` holds:
  - the opcode constants `OP_CLR`…`OP_DEC` (4-bit localparams);
  - widths `INSTR_W=12` and `DATA_W=8`.
- A sub-module `mini_cpu_alu` is purely combinational:
  - inputs `op[3:0]`, `a[7:0]`, `b[7:0]`;
  - outputs `y[7:0]`, `ovf`, and `wr_en`, which is low for NOP.
- The top level holds the `ACC` and `OVERFLOW` registers plus the opcode/immediate field decode.

## Test plan
- Reset: drive `RST_N` low mid-cycle after loading 0x55 -> `RESULT`=0x00 and `OVERFLOW`=0 before the next edge. After release, CLR (0x000) -> `RESULT` stays 0x00.
- Load: 0x1FF -> `RESULT`=0xFF; then 0x101 -> 0x01; then 0x180 -> 0x80. `OVERFLOW`=0 throughout.
- Add overflow:
  - LDI 0x7F, then ADD 0x01 (0x201) -> `RESULT`=0x80, `OVERFLOW`=1.
  - Then ADD 0x00 (0x200) -> `RESULT`=0x80, `OVERFLOW`=0.
  - LDI 0xFF, then ADD 0x01 -> 0x00, `OVERFLOW`=0 (unsigned carry only).
- Subtract:
  - LDI 0x80, then SUB 0x01 -> 0x7F, `OVERFLOW`=1.
  - LDI 0x05, then SUB 0x07 -> 0xFE, `OVERFLOW`=0.
- Logic and shift:
  - LDI 0xF0, then XOR 0xFF -> 0x0F; then NOT -> 0xF0.
  - SHL 0x01 -> 0xE0, `OVERFLOW`=1.
  - SHR 0x04 -> 0x0E, `OVERFLOW`=0.
- NOP and hold:
  - After ADD produces `OVERFLOW`=1, opcode 0xC -> `RESULT` and `OVERFLOW` are unchanged.
  - INC held for 3 edges from 0x7E -> 0x7F (flag 0), 0x80 (flag 1), 0x81 (flag 0).
